// File: rtl/ide_taskfile_buffer_if.sv
// HPS and Gayle CPU register/buffer access bus of the IDE task-file buffer.
// The master drives addresses, strobes and write data; the slave returns read data, requests and INTRQ.
interface ide_taskfile_buffer_if;
    logic [4:0]  hps_addr;
    logic        hps_rd;
    logic        hps_wr;
    logic [15:0] hps_din;
    logic [15:0] hps_dout;
    logic [5:0]  hps_req;

    logic [3:0]  cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_irq;

    modport master (
        output hps_addr, hps_rd, hps_wr, hps_din,
        output cpu_addr, cpu_rd, cpu_wr, cpu_din,
        input  hps_dout, hps_req, cpu_dout, cpu_irq
    );

    modport slave (
        input  hps_addr, hps_rd, hps_wr, hps_din,
        input  cpu_addr, cpu_rd, cpu_wr, cpu_din,
        output hps_dout, hps_req, cpu_dout, cpu_irq
    );
endinterface

// File: rtl/ide_taskfile_buffer.sv
// ATA task file plus a 256-word sector buffer shared between HPS firmware and the Gayle CPU port.
// Read data settles within 2 clk of an address/pointer change; strobes are single-cycle, no backpressure.
module ide_taskfile_buffer #(
    parameter int unsigned BUF_AW   = 8,
    parameter logic [7:0]  RST_STAT = 8'h50
) (
    input logic                  clk_sys,
    input logic                  reset,
    ide_taskfile_buffer_if.slave bus
);
    localparam int BSY = 7;
    localparam int DRQ = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOST_FILL  = 3'd1,
        CPU_READ   = 3'd2,
        CPU_WRITE  = 3'd3,
        HOST_DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_AW-1:0] ptr_q, ptr_d;
    logic [7:0]        status_q, status_d;
    logic [7:0]        feat_q, feat_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        tf_q [1:6];
    logic [7:0]        tf_d [1:6];
    logic [3:0]        req_q, req_d;
    logic              irq_q, irq_d;
    logic              irq_en_q, irq_en_d;

    logic [15:0]       buf_mem [0:(1<<BUF_AW)-1];
    logic [15:0]       buf_rdata_q;
    logic [15:0]       hps_dout_q, hps_dout_d;
    logic [15:0]       cpu_dout_q, cpu_dout_d;

    logic              hps_buf_wr, hps_buf_rd, cpu_buf_wr, cpu_buf_rd;
    logic              wrap;

    // Buffer strobes only count when the issuing side owns the current phase.
    assign hps_buf_wr = bus.hps_wr && (bus.hps_addr == 5'h0F) && (state_q == HOST_FILL);
    assign hps_buf_rd = bus.hps_rd && (bus.hps_addr == 5'h0F) && (state_q == HOST_DRAIN);
    assign cpu_buf_wr = bus.cpu_wr && (bus.cpu_addr == 4'h0) && (state_q == CPU_WRITE);
    assign cpu_buf_rd = bus.cpu_rd && (bus.cpu_addr == 4'h0) && (state_q == CPU_READ);
    assign wrap       = &ptr_q;

    always_ff @(posedge clk_sys) begin
        if (hps_buf_wr) begin
            buf_mem[ptr_q] <= bus.hps_din;
        end else if (cpu_buf_wr) begin
            buf_mem[ptr_q] <= bus.cpu_din;
        end
        buf_rdata_q <= buf_mem[ptr_q];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            status_q   <= RST_STAT;
            feat_q     <= '0;
            cmd_q      <= '0;
            for (int i = 1; i <= 6; i++) begin
                tf_q[i] <= '0;
            end
            req_q      <= '0;
            irq_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            hps_dout_q <= '0;
            cpu_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            status_q   <= status_d;
            feat_q     <= feat_d;
            cmd_q      <= cmd_d;
            tf_q       <= tf_d;
            req_q      <= req_d;
            irq_q      <= irq_d;
            irq_en_q   <= irq_en_d;
            hps_dout_q <= hps_dout_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    // Later assignments override earlier ones: transfer progress < HPS writes < CPU command < SRST.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        status_d = status_q;
        feat_d   = feat_q;
        cmd_d    = cmd_q;
        tf_d     = tf_q;
        req_d    = req_q;
        irq_d    = irq_q;
        irq_en_d = irq_en_q;

        case (state_q)
            HOST_FILL: begin
                if (hps_buf_wr) begin
                    ptr_d = ptr_q + 1'b1;
                    if (wrap) begin
                        state_d       = CPU_READ;
                        status_d[DRQ] = 1'b1;
                        status_d[BSY] = 1'b0;
                        irq_d         = irq_en_q;
                    end
                end
            end
            CPU_READ: begin
                if (cpu_buf_rd) begin
                    ptr_d = ptr_q + 1'b1;
                    if (wrap) begin
                        state_d       = IDLE;
                        status_d[DRQ] = 1'b0;
                        status_d[BSY] = 1'b1;
                        req_d[3]      = 1'b1;
                    end
                end
            end
            CPU_WRITE: begin
                if (cpu_buf_wr) begin
                    ptr_d = ptr_q + 1'b1;
                    if (wrap) begin
                        state_d       = HOST_DRAIN;
                        status_d[DRQ] = 1'b0;
                        status_d[BSY] = 1'b1;
                        req_d[1]      = 1'b1;
                    end
                end
            end
            HOST_DRAIN: begin
                if (hps_buf_rd) begin
                    ptr_d = ptr_q + 1'b1;
                    if (wrap) begin
                        state_d  = IDLE;
                        req_d[1] = 1'b0;
                        req_d[3] = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Reading the status register acknowledges INTRQ; altstat deliberately does not.
        if (bus.cpu_rd && (bus.cpu_addr == 4'h7)) begin
            irq_d = 1'b0;
        end

        if (bus.hps_wr) begin
            case (bus.hps_addr)
                5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06: begin
                    tf_d[bus.hps_addr[2:0]] = bus.hps_din[7:0];
                end
                5'h07: begin
                    status_d = bus.hps_din[7:0];
                    req_d[0] = 1'b0;
                    req_d[2] = 1'b0;
                    state_d  = IDLE;
                    if (bus.hps_din[15]) begin
                        irq_d = 1'b1;
                    end
                end
                5'h10: begin
                    irq_en_d = bus.hps_din[2];
                    ptr_d    = '0;
                    req_d[3] = 1'b0;
                    case (bus.hps_din[1:0])
                        2'b01:   state_d = HOST_FILL;
                        2'b10: begin
                            state_d       = CPU_WRITE;
                            status_d[DRQ] = 1'b1;
                            status_d[BSY] = 1'b0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
                default: ;
            endcase
        end

        if (bus.cpu_wr) begin
            case (bus.cpu_addr)
                4'h1: feat_d = bus.cpu_din[7:0];
                4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                    tf_d[bus.cpu_addr[2:0]] = bus.cpu_din[7:0];
                end
                4'h7: begin
                    cmd_d         = bus.cpu_din[7:0];
                    status_d[BSY] = 1'b1;
                    status_d[DRQ] = 1'b0;
                    req_d[0]      = 1'b1;
                    irq_d         = 1'b0;
                    ptr_d         = '0;
                    state_d       = IDLE;
                end
                default: ;
            endcase
        end

        if (bus.cpu_wr && (bus.cpu_addr == 4'h8) && bus.cpu_din[2]) begin
            req_d[2]      = 1'b1;
            status_d[BSY] = 1'b1;
            state_d       = IDLE;
        end
    end

    always_comb begin
        hps_dout_d = '0;
        case (bus.hps_addr)
            5'h00: hps_dout_d = 16'(ptr_q);
            5'h01: hps_dout_d = {8'h00, feat_q};
            5'h02, 5'h03, 5'h04, 5'h05, 5'h06: hps_dout_d = {8'h00, tf_q[bus.hps_addr[2:0]]};
            5'h07: hps_dout_d = {cmd_q, status_q};
            5'h0F: if (state_q == HOST_DRAIN) hps_dout_d = buf_rdata_q;
            5'h10: hps_dout_d = {12'h000, irq_en_q, state_q};
            default: ;
        endcase
    end

    always_comb begin
        cpu_dout_d = '0;
        case (bus.cpu_addr)
            4'h0: if (state_q == CPU_READ || state_q == CPU_WRITE) cpu_dout_d = buf_rdata_q;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: cpu_dout_d = {8'h00, tf_q[bus.cpu_addr[2:0]]};
            4'h7, 4'h8: cpu_dout_d = {8'h00, status_q};
            default: ;
        endcase
    end

    assign bus.hps_dout = hps_dout_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.hps_req  = {status_q[DRQ], status_q[BSY], req_q};
    assign bus.cpu_irq  = irq_q;
endmodule

// File: tb/tb_ide_taskfile_buffer.sv
// Directed bench for ide_taskfile_buffer: command handshake, both buffer directions, reset abort, collisions.
module tb_ide_taskfile_buffer;
    logic clk_sys = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   errs;
    logic [15:0] d;

    ide_taskfile_buffer_if bus();

    ide_taskfile_buffer #(.BUF_AW(8), .RST_STAT(8'h50)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic hps_write(input logic [4:0] a, input logic [15:0] v);
        @(negedge clk_sys);
        bus.hps_addr = a; bus.hps_din = v; bus.hps_wr = 1'b1;
        @(negedge clk_sys);
        bus.hps_wr = 1'b0;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk_sys);
        bus.cpu_addr = a; bus.cpu_din = v; bus.cpu_wr = 1'b1;
        @(negedge clk_sys);
        bus.cpu_wr = 1'b0;
    endtask

    task automatic hps_peek(input logic [4:0] a, output logic [15:0] v);
        @(negedge clk_sys);
        bus.hps_addr = a;
        ticks(3);
        v = bus.hps_dout;
    endtask

    task automatic cpu_peek(input logic [3:0] a, output logic [15:0] v);
        @(negedge clk_sys);
        bus.cpu_addr = a;
        ticks(3);
        v = bus.cpu_dout;
    endtask

    task automatic hps_read(input logic [4:0] a, output logic [15:0] v);
        hps_peek(a, v);
        bus.hps_rd = 1'b1;
        @(negedge clk_sys);
        bus.hps_rd = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [15:0] v);
        cpu_peek(a, v);
        bus.cpu_rd = 1'b1;
        @(negedge clk_sys);
        bus.cpu_rd = 1'b0;
    endtask

    initial begin
        bus.hps_addr = '0; bus.hps_rd = 1'b0; bus.hps_wr = 1'b0; bus.hps_din = '0;
        bus.cpu_addr = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_din = '0;
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;

        check("rst_req", 32'(bus.hps_req), 32'h00);
        check("rst_irq", 32'(bus.cpu_irq), 32'h0);
        cpu_peek(4'h8, d);
        check("rst_altstat", 32'(d), 32'h0050);
        hps_peek(5'h00, d);
        check("rst_ptr", 32'(d), 32'h0000);

        // Command issue
        cpu_write(4'h7, 16'h0020);
        check("cmd_req", 32'(bus.hps_req), 32'b010001);
        cpu_peek(4'h7, d);
        check("cmd_status", 32'(d), 32'h00D0);
        hps_peek(5'h07, d);
        check("hps_cmd_status", 32'(d), 32'h20D0);
        hps_write(5'h01, 16'h0004);
        cpu_peek(4'h1, d);
        check("error_reg", 32'(d), 32'h0004);
        hps_write(5'h07, 16'h0050);
        check("status_ack_req", 32'(bus.hps_req), 32'h00);

        // HPS fills the buffer for a CPU read
        hps_write(5'h10, 16'h0005);
        for (int n = 0; n < 256; n++) begin
            hps_write(5'h0F, 16'(n));
            if (n == 254) begin
                check("fill_255_req", 32'(bus.hps_req), 32'h00);
                hps_peek(5'h00, d);
                check("fill_255_ptr", 32'(d), 32'h00FF);
            end
        end
        check("fill_done_req", 32'(bus.hps_req), 32'b100000);
        check("fill_done_irq", 32'(bus.cpu_irq), 32'h1);
        cpu_peek(4'h8, d);
        check("fill_altstat", 32'(d), 32'h0058);
        hps_read(5'h0F, d);
        check("hps_nonowner_data", 32'(d), 32'h0000);
        hps_peek(5'h00, d);
        check("hps_nonowner_ptr", 32'(d), 32'h0000);

        errs = 0;
        for (int n = 0; n < 256; n++) begin
            cpu_read(4'h0, d);
            if (n == 0) check("cpu_rd_first", 32'(d), 32'h0000);
            if (n == 255) check("cpu_rd_last", 32'(d), 32'h00FF);
            if (d !== 16'(n)) errs++;
        end
        check("cpu_rd_errs", 32'(errs), 32'd0);
        check("cpu_rd_done_req", 32'(bus.hps_req), 32'b011000);
        check("irq_after_altstat", 32'(bus.cpu_irq), 32'h1);
        cpu_peek(4'h0, d);
        check("cpu_idle_data", 32'(d), 32'h0000);
        cpu_read(4'h7, d);
        check("status_read", 32'(d), 32'h00D0);
        check("irq_cleared", 32'(bus.cpu_irq), 32'h0);

        // CPU write, HPS drain
        hps_write(5'h10, 16'h0002);
        check("wr_start_req", 32'(bus.hps_req), 32'b100000);
        for (int n = 0; n < 256; n++) begin
            cpu_write(4'h0, 16'hA5A5 ^ 16'(n));
            if (n == 254) check("cpu_wr_255_req", 32'(bus.hps_req), 32'b100000);
        end
        check("cpu_wr_done_req", 32'(bus.hps_req), 32'b010010);
        cpu_peek(4'h0, d);
        check("cpu_nonowner_data", 32'(d), 32'h0000);
        errs = 0;
        for (int n = 0; n < 256; n++) begin
            hps_read(5'h0F, d);
            if (n == 0) check("drain_first", 32'(d), 32'hA5A5);
            if (n == 254) check("drain_255_req", 32'(bus.hps_req), 32'b010010);
            if (d !== (16'hA5A5 ^ 16'(n))) errs++;
        end
        check("drain_errs", 32'(errs), 32'd0);
        check("drain_done_req", 32'(bus.hps_req), 32'b011000);

        // Reset in the middle of a fill
        hps_write(5'h10, 16'h0001);
        for (int n = 0; n < 100; n++) hps_write(5'h0F, 16'(n));
        hps_peek(5'h00, d);
        check("mid_fill_ptr", 32'(d), 32'd100);
        @(negedge clk_sys);
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        check("abort_req", 32'(bus.hps_req), 32'h00);
        hps_peek(5'h00, d);
        check("abort_ptr", 32'(d), 32'h0000);
        hps_peek(5'h10, d);
        check("abort_state", 32'(d), 32'h0000);
        cpu_peek(4'h8, d);
        check("abort_status", 32'(d), 32'h0050);
        hps_write(5'h0F, 16'h1234);
        hps_peek(5'h00, d);
        check("idle_fill_ignored", 32'(d), 32'h0000);

        // Same-cycle collisions
        @(negedge clk_sys);
        bus.hps_addr = 5'h07; bus.hps_din = 16'h8050; bus.hps_wr = 1'b1;
        bus.cpu_addr = 4'h7;  bus.cpu_din = 16'h00EC; bus.cpu_wr = 1'b1;
        @(negedge clk_sys);
        bus.hps_wr = 1'b0; bus.cpu_wr = 1'b0;
        check("collide_req", 32'(bus.hps_req), 32'b010001);
        check("collide_irq", 32'(bus.cpu_irq), 32'h0);
        cpu_write(4'h8, 16'h0004);
        check("srst_req", 32'(bus.hps_req), 32'b010101);
        hps_write(5'h07, 16'h8050);
        check("hps_irq_req", 32'(bus.hps_req), 32'h00);
        check("hps_irq_set", 32'(bus.cpu_irq), 32'h1);
        cpu_read(4'h7, d);
        check("irq_ack_status", 32'(d), 32'h0050);
        check("irq_ack", 32'(bus.cpu_irq), 32'h0);

        @(negedge clk_sys);
        bus.hps_addr = 5'h07; bus.hps_din = 16'h0050; bus.hps_wr = 1'b1;
        bus.cpu_addr = 4'h8;  bus.cpu_din = 16'h0004; bus.cpu_wr = 1'b1;
        @(negedge clk_sys);
        bus.hps_wr = 1'b0; bus.cpu_wr = 1'b0;
        check("srst_vs_status", 32'(bus.hps_req), 32'b010100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
